// File: rtl/fetch_controller.sv
// Instruction fetch front end: issues sequential word fetches into a 2-entry
// output FIFO, handles redirects, and latches a sticky fault on bad addresses.
module fetch_controller #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          MEM_BYTES = 128
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] mem_address,
  input  logic [31:0] mem_read_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

  localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        inflight_reg, inflight_next;
  logic [31:0] inflight_pc_reg, inflight_pc_next;
  logic [1:0]  count_reg, count_next;
  logic        rd_ptr_reg, rd_ptr_next;
  logic        wr_ptr_reg, wr_ptr_next;
  logic        fault_reg, fault_next;
  logic [31:0] fault_pc_reg, fault_pc_next;
  logic [31:0] buf_instr_reg [2];
  logic [31:0] buf_pc_reg [2];

  logic pop, issue, flush, capture;

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    fault_next    = fault_reg;
    fault_pc_next = fault_pc_reg;
    issue         = 1'b0;
    flush         = 1'b0;
    pop           = (count_reg != 2'd0) && out_ready;

    case (state_reg)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        if (redirect_valid) begin
          flush = 1'b1;
          if (redirect_target[1:0] != 2'b00 || redirect_target > LAST_ADDR) begin
            state_next    = FAULT;
            fault_next    = 1'b1;
            fault_pc_next = redirect_target;
          end else begin
            pc_next = redirect_target;
          end
        end else if ((count_reg + {1'b0, inflight_reg}) < 2'd2 || pop) begin
          // Running off the end of memory faults instead of issuing.
          if (pc_reg > LAST_ADDR) begin
            state_next    = FAULT;
            fault_next    = 1'b1;
            fault_pc_next = pc_reg;
          end else begin
            issue   = 1'b1;
            pc_next = pc_reg + 32'd4;
          end
        end
      end
      FAULT: ;
      default: state_next = IDLE;
    endcase

    // Memory data is only present for one cycle, so an inflight fetch is always captured unless flushed.
    capture          = inflight_reg && !flush;
    inflight_next    = issue;
    inflight_pc_next = issue ? pc_reg : inflight_pc_reg;

    if (flush) begin
      count_next  = 2'd0;
      rd_ptr_next = 1'b0;
      wr_ptr_next = 1'b0;
    end else begin
      count_next  = count_reg + {1'b0, capture} - {1'b0, pop};
      rd_ptr_next = rd_ptr_reg ^ pop;
      wr_ptr_next = wr_ptr_reg ^ capture;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      pc_reg          <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= 32'd0;
      count_reg       <= 2'd0;
      rd_ptr_reg      <= 1'b0;
      wr_ptr_reg      <= 1'b0;
      fault_reg       <= 1'b0;
      fault_pc_reg    <= 32'd0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      inflight_reg    <= inflight_next;
      inflight_pc_reg <= inflight_pc_next;
      count_reg       <= count_next;
      rd_ptr_reg      <= rd_ptr_next;
      wr_ptr_reg      <= wr_ptr_next;
      fault_reg       <= fault_next;
      fault_pc_reg    <= fault_pc_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        buf_instr_reg[i] <= 32'd0;
        buf_pc_reg[i]    <= 32'd0;
      end
    end else if (capture) begin
      buf_instr_reg[wr_ptr_reg] <= mem_read_instr;
      buf_pc_reg[wr_ptr_reg]    <= inflight_pc_reg;
    end
  end

  assign mem_address = pc_reg;
  assign out_valid   = (count_reg != 2'd0);
  assign out_instr   = buf_instr_reg[rd_ptr_reg];
  assign out_pc      = buf_pc_reg[rd_ptr_reg];
  assign fault       = fault_reg;
  assign fault_pc    = fault_pc_reg;

  // The issue rule keeps the FIFO from ever holding a third entry.
  assert property (@(posedge clock) disable iff (reset)
    !(capture && !pop && count_reg == 2'd2));

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed latency/stall/redirect/fault
// scenarios plus randomized runs scored against an in-order address-stream model.
module tb_fetch_controller;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        out_ready = 1'b0;
  logic [31:0] mem_read_instr = 32'd0;
  logic [31:0] mem_address, out_instr, out_pc, fault_pc;
  logic        out_valid, fault;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] mem [32];

  fetch_controller #(.RESET_PC(32'h0), .MEM_BYTES(128)) dut (
    .clock(clock), .reset(reset), .start(start),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .mem_address(mem_address), .mem_read_instr(mem_read_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .fault(fault), .fault_pc(fault_pc)
  );

  always #5 clock = ~clock;

  // Synchronous-read instruction memory: data appears the cycle after the address.
  always @(posedge clock)
    mem_read_instr <= (mem_address < 32'd128) ? mem[mem_address[6:2]] : 32'hDEADBEEF;

  function automatic logic [31:0] ref_instr(input logic [31:0] addr);
    return mem[addr[6:2]];
  endfunction

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests_run++; if (out_pc !== 32'd0) begin tests_failed++; $display("FAIL reset_out_pc: got %h expected 0", out_pc); end
    tests_run++; if (out_instr !== 32'd0) begin tests_failed++; $display("FAIL reset_out_instr: got %h expected 0", out_instr); end
    tests_run++; if (mem_address !== 32'd0) begin tests_failed++; $display("FAIL reset_mem_address: got %h expected 0", mem_address); end
    tests_run++; if (fault !== 1'b0 || fault_pc !== 32'd0) begin tests_failed++; $display("FAIL reset_fault: got %b/%h expected 0/0", fault, fault_pc); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    tests_run++; if (out_valid !== 1'b0 || mem_address !== 32'd0) begin tests_failed++; $display("FAIL idle_wait: got valid=%b addr=%h expected 0/0", out_valid, mem_address); end
    $display("[TB] reset test done");
  endtask

  task automatic test_latency();
    do_reset();
    out_ready = 1'b1; start = 1'b1;
    @(negedge clock); start = 1'b0;
    tests_run++; if (out_valid !== 1'b0 || mem_address !== 32'd0) begin tests_failed++; $display("FAIL lat_s1: got valid=%b addr=%h expected 0/0", out_valid, mem_address); end
    @(negedge clock);
    tests_run++; if (out_valid !== 1'b0 || mem_address !== 32'd4) begin tests_failed++; $display("FAIL lat_s2: got valid=%b addr=%h expected 0/4", out_valid, mem_address); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      tests_run++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== ref_instr(32'(4 * k))) begin
        tests_failed++;
        $display("FAIL lat_stream%0d: got valid=%b pc=%h instr=%h expected 1/%h/%h", k, out_valid, out_pc, out_instr, 32'(4 * k), ref_instr(32'(4 * k)));
      end
      $display("[TB] pop pc=%h instr=%h", out_pc, out_instr);
    end
  endtask

  task automatic test_stall();
    int waited = 0;
    do_reset();
    out_ready = 1'b0; start = 1'b1;
    @(negedge clock); start = 1'b0;
    while (!out_valid && waited < 20) begin @(negedge clock); waited++; end
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_timeout: got valid=%b expected 1", out_valid); end
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_pc !== 32'd0 || out_instr !== ref_instr(32'd0) || mem_address !== 32'd8) begin
        tests_failed++;
        $display("FAIL stall_hold%0d: got valid=%b pc=%h addr=%h expected 1/0/8", k, out_valid, out_pc, mem_address);
      end
      @(negedge clock);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clock);
      tests_run++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== ref_instr(32'(4 * k))) begin
        tests_failed++;
        $display("FAIL stall_release%0d: got valid=%b pc=%h expected 1/%h", k, out_valid, out_pc, 32'(4 * k));
      end
      $display("[TB] pop pc=%h instr=%h", out_pc, out_instr);
    end
  endtask

  task automatic test_redirect();
    int waited = 0;
    do_reset();
    out_ready = 1'b1; start = 1'b1;
    @(negedge clock); start = 1'b0;
    while (!(out_valid && out_pc == 32'd16) && waited < 30) begin @(negedge clock); waited++; end
    tests_run++; if (out_valid !== 1'b1 || out_pc !== 32'd16) begin tests_failed++; $display("FAIL redir_reach16: got pc=%h expected 10", out_pc); end
    redirect_valid = 1'b1; redirect_target = 32'd28;
    @(negedge clock); redirect_valid = 1'b0;
    tests_run++; if (out_valid !== 1'b0 || mem_address !== 32'd28) begin tests_failed++; $display("FAIL redir_r1: got valid=%b pc=%h addr=%h expected 0/-/1c", out_valid, out_pc, mem_address); end
    @(negedge clock);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_r2: got valid=%b pc=%h expected 0", out_valid, out_pc); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      start = (k == 1);
      tests_run++;
      if (out_valid !== 1'b1 || out_pc !== 32'(28 + 4 * k) || out_instr !== ref_instr(32'(28 + 4 * k))) begin
        tests_failed++;
        $display("FAIL redir_stream%0d: got valid=%b pc=%h expected 1/%h", k, out_valid, out_pc, 32'(28 + 4 * k));
      end
      $display("[TB] pop pc=%h instr=%h", out_pc, out_instr);
    end
    start = 1'b0;
  endtask

  task automatic test_bad_redirect();
    int waited = 0;
    do_reset();
    out_ready = 1'b1; start = 1'b1;
    @(negedge clock); start = 1'b0;
    while (!out_valid && waited < 20) begin @(negedge clock); waited++; end
    tests_run++; if (out_valid !== 1'b1 || out_pc !== 32'd0 || mem_address !== 32'd8) begin tests_failed++; $display("FAIL badredir_pre: got valid=%b pc=%h addr=%h expected 1/0/8", out_valid, out_pc, mem_address); end
    redirect_valid = 1'b1; redirect_target = 32'd30;
    @(negedge clock);
    tests_run++; if (fault !== 1'b1 || fault_pc !== 32'd30 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL badredir_fault: got fault=%b fault_pc=%h valid=%b expected 1/1e/0", fault, fault_pc, out_valid); end
    redirect_target = 32'd8; start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      tests_run++;
      if (mem_address !== 32'd8 || fault !== 1'b1 || fault_pc !== 32'd30 || out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL badredir_hold%0d: got addr=%h fault=%b fault_pc=%h valid=%b expected 8/1/1e/0", k, mem_address, fault, fault_pc, out_valid);
      end
    end
    redirect_valid = 1'b0; start = 1'b0;
    $display("[TB] bad redirect fault_pc=%h", fault_pc);
  endtask

  task automatic test_sequential_end();
    logic [31:0] exp_pc = 32'd0;
    logic [31:0] prev_pc = 32'd0;
    logic [31:0] prev_instr = 32'd0;
    logic        prev_hold = 1'b0;
    int          pops = 0;
    int          cyc = 0;
    do_reset();
    start = 1'b1;
    @(negedge clock); start = 1'b0;
    while (exp_pc != 32'd128 && cyc < 2000) begin
      if (prev_hold) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_pc !== prev_pc || out_instr !== prev_instr) begin
          tests_failed++;
          $display("FAIL seq_hold: got valid=%b pc=%h instr=%h expected 1/%h/%h", out_valid, out_pc, out_instr, prev_pc, prev_instr);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      prev_hold = out_valid && !out_ready;
      prev_pc = out_pc; prev_instr = out_instr;
      if (out_valid && out_ready) begin
        tests_run++;
        if (out_pc !== exp_pc || out_instr !== ref_instr(exp_pc)) begin
          tests_failed++;
          $display("FAIL seq_pop: got pc=%h instr=%h expected %h/%h", out_pc, out_instr, exp_pc, ref_instr(exp_pc));
        end
        $display("[TB] pop pc=%h instr=%h", out_pc, out_instr);
        exp_pc += 32'd4; pops++;
      end
      @(negedge clock); cyc++;
    end
    tests_run++; if (pops != 32) begin tests_failed++; $display("FAIL seq_pop_count: got %0d expected 32", pops); end
    tests_run++; if (fault !== 1'b1 || fault_pc !== 32'd128) begin tests_failed++; $display("FAIL seq_fault: got fault=%b fault_pc=%h expected 1/80", fault, fault_pc); end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (out_valid !== 1'b0 || mem_address !== 32'd128) begin
        tests_failed++;
        $display("FAIL seq_after_end%0d: got valid=%b pc=%h addr=%h expected 0/-/80", k, out_valid, out_pc, mem_address);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_random_redirect();
    logic [31:0] exp_pc = 32'd0;
    logic        redir;
    int          pops = 0;
    do_reset();
    start = 1'b1;
    @(negedge clock); start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (fault === 1'b1 && out_valid === 1'b0) begin
        tests_run++; if (fault_pc !== 32'd128) begin tests_failed++; $display("FAIL rnd_fault_pc: got %h expected 80", fault_pc); end
        redirect_valid = 1'b0; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; start = 1'b1; exp_pc = 32'd0;
        @(negedge clock);
        start = 1'b0;
        continue;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      redir = (fault === 1'b0) && ($urandom_range(0, 15) == 0);
      redirect_valid = redir;
      redirect_target = 32'($urandom_range(0, 31)) << 2;
      start = ($urandom_range(0, 31) == 0);
      if (out_valid && out_ready) begin
        tests_run++;
        if (out_pc !== exp_pc || out_instr !== ref_instr(exp_pc)) begin
          tests_failed++;
          $display("FAIL rnd_pop: got pc=%h instr=%h expected %h/%h", out_pc, out_instr, exp_pc, ref_instr(exp_pc));
        end
        $display("[TB] pop pc=%h instr=%h%s", out_pc, out_instr, redir ? " (redirect)" : "");
        exp_pc += 32'd4; pops++;
      end
      if (redir) exp_pc = redirect_target;
      @(negedge clock);
    end
    redirect_valid = 1'b0; start = 1'b0;
    tests_run++; if (pops < 40) begin tests_failed++; $display("FAIL rnd_progress: got %0d pops expected at least 40", pops); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    out_ready = 1'b1; start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (6) @(negedge clock);
    tests_run++; if (out_valid !== 1'b1 || out_instr === 32'd0) begin tests_failed++; $display("FAIL midrun_pre: got valid=%b instr=%h expected 1/nonzero", out_valid, out_instr); end
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_pc !== 32'd0 || out_instr !== 32'd0 || mem_address !== 32'd0 || fault !== 1'b0 || fault_pc !== 32'd0) begin
      tests_failed++;
      $display("FAIL midrun_async: got valid=%b pc=%h instr=%h addr=%h fault=%b expected all 0", out_valid, out_pc, out_instr, mem_address, fault);
    end
    @(negedge clock); reset = 1'b0;
    repeat (2) @(negedge clock);
    tests_run++; if (out_valid !== 1'b0 || mem_address !== 32'd0) begin tests_failed++; $display("FAIL midrun_idle: got valid=%b addr=%h expected 0/0", out_valid, mem_address); end
    start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (2) @(negedge clock);
    tests_run++; if (out_valid !== 1'b1 || out_pc !== 32'd0 || out_instr !== ref_instr(32'd0)) begin tests_failed++; $display("FAIL midrun_restart: got valid=%b pc=%h expected 1/0", out_valid, out_pc); end
    $display("[TB] pop pc=%h instr=%h", out_pc, out_instr);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[0] = 32'h01400193;
    mem[1] = 32'h0781A403;
    mem[2] = 32'h00340533;
    test_reset();
    test_latency();
    test_stall();
    test_redirect();
    test_bad_redirect();
    test_sequential_end();
    test_random_redirect();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
